// File: rtl/axis_nchan_adder.sv
// axis_nchan_adder: joins NUM_CH AXI-Stream inputs beat-by-beat and emits the
// per-sample signed sum of the enabled channels through a 2-entry output FIFO.
// Optional build macro AXIS_ADDER_SAT_EN: saturate each sum to the input sample
// width instead of emitting the full-width sum.
module axis_nchan_adder #(
    parameter int NUM_CH        = 4,
    parameter int SSAMPLE_WIDTH = 16,
    parameter int SAMPLES       = 16,
`ifdef AXIS_ADDER_SAT_EN
    localparam int MSAMPLE_WIDTH = SSAMPLE_WIDTH
`else
    localparam int MSAMPLE_WIDTH = SSAMPLE_WIDTH + $clog2(NUM_CH)
`endif
) (
    input  logic                                    CLK,
    input  logic                                    resetn,
    input  logic [NUM_CH*SAMPLES*SSAMPLE_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]                       s_axis_tvalid,
    output logic [NUM_CH-1:0]                       s_axis_tready,
    input  logic [NUM_CH-1:0]                       s_axis_tlast,
    input  logic [NUM_CH-1:0]                       ch_en,
    output logic [SAMPLES*MSAMPLE_WIDTH-1:0]        m_axis_tdata,
    output logic                                    m_axis_tvalid,
    input  logic                                    m_axis_tready,
    output logic                                    m_axis_tlast,
    output logic [31:0]                             beat_cnt,
    output logic                                    err_tlast
);

    localparam int FULL_W = SSAMPLE_WIDTH + $clog2(NUM_CH);
    localparam int OUT_W  = SAMPLES * MSAMPLE_WIDTH;

`ifdef AXIS_ADDER_SAT_EN
    localparam logic signed [FULL_W-1:0] SAT_MAX =
        {{(FULL_W-SSAMPLE_WIDTH+1){1'b0}}, {(SSAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [FULL_W-1:0] SAT_MIN =
        {{(FULL_W-SSAMPLE_WIDTH+1){1'b1}}, {(SSAMPLE_WIDTH-1){1'b0}}};
`endif

    logic [1:0]       fill;
    logic [OUT_W-1:0] head_data;
    logic             head_last;
    logic [OUT_W-1:0] tail_data;
    logic             tail_last;
    logic [OUT_W-1:0] sum_data;
    logic             accept;
    logic             pop;
    logic [NUM_CH-1:0] last_en;
    logic             last_or;
    logic             last_mismatch;

    // resetn is folded into accept so tready is forced low while reset is held
    assign accept = resetn & (|ch_en) & (&(s_axis_tvalid | ~ch_en)) & (fill < 2'd2);
    assign pop    = m_axis_tvalid & m_axis_tready;

    assign s_axis_tready = {NUM_CH{accept}} & ch_en;
    assign m_axis_tvalid = (fill != 2'd0);
    assign m_axis_tdata  = head_data;
    assign m_axis_tlast  = head_last;

    assign last_en       = s_axis_tlast & ch_en;
    assign last_or       = |last_en;
    assign last_mismatch = last_or && (last_en != ch_en);

    // Per-sample sum of enabled channels at full width, optionally saturated
    always_comb begin
        logic signed [FULL_W-1:0] acc;
        sum_data = '0;
        acc      = '0;
        for (int unsigned i = 0; i < SAMPLES; i++) begin
            acc = '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (ch_en[c]) begin
                    acc = acc + FULL_W'($signed(
                        s_axis_tdata[(c*SAMPLES+i)*SSAMPLE_WIDTH +: SSAMPLE_WIDTH]));
                end
            end
`ifdef AXIS_ADDER_SAT_EN
            if (acc > SAT_MAX) begin
                sum_data[i*MSAMPLE_WIDTH +: MSAMPLE_WIDTH] = SAT_MAX[SSAMPLE_WIDTH-1:0];
            end else if (acc < SAT_MIN) begin
                sum_data[i*MSAMPLE_WIDTH +: MSAMPLE_WIDTH] = SAT_MIN[SSAMPLE_WIDTH-1:0];
            end else begin
                sum_data[i*MSAMPLE_WIDTH +: MSAMPLE_WIDTH] = acc[SSAMPLE_WIDTH-1:0];
            end
`else
            sum_data[i*MSAMPLE_WIDTH +: MSAMPLE_WIDTH] = acc;
`endif
        end
    end

    // Two-entry output FIFO: head drives the master port, tail holds the overflow beat
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            fill      <= 2'd0;
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else begin
            case ({accept, pop})
                2'b10: begin
                    if (fill == 2'd0) begin
                        head_data <= sum_data;
                        head_last <= last_or;
                    end else begin
                        tail_data <= sum_data;
                        tail_last <= last_or;
                    end
                    fill <= fill + 2'd1;
                end
                2'b01: begin
                    if (fill == 2'd2) begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                    end
                    fill <= fill - 2'd1;
                end
                2'b11: begin
                    // accept needs fill<2 and pop needs fill>0, so fill is 1 here
                    head_data <= sum_data;
                    head_last <= last_or;
                end
                default: ;
            endcase
        end
    end

    // Output beat counter and sticky tlast-disagreement flag
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            beat_cnt  <= '0;
            err_tlast <= 1'b0;
        end else begin
            if (pop) begin
                beat_cnt <= beat_cnt + 32'd1;
            end
            if (accept && last_mismatch) begin
                err_tlast <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_nchan_adder.sv
// Randomized bench for axis_nchan_adder with a queue-based reference model.
module tb_axis_nchan_adder;

    localparam int NC  = 4;
    localparam int SW  = 16;
    localparam int NS  = 16;
`ifdef AXIS_ADDER_SAT_EN
    localparam int MW  = SW;
`else
    localparam int MW  = SW + $clog2(NC);
`endif
    localparam int DW  = NC * NS * SW;
    localparam int DOW = NS * MW;

    logic            CLK = 1'b0;
    logic            resetn;
    logic [DW-1:0]   s_axis_tdata;
    logic [NC-1:0]   s_axis_tvalid;
    logic [NC-1:0]   s_axis_tready;
    logic [NC-1:0]   s_axis_tlast;
    logic [NC-1:0]   ch_en;
    logic [DOW-1:0]  m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic [31:0]     beat_cnt;
    logic            err_tlast;

    axis_nchan_adder #(.NUM_CH(NC), .SSAMPLE_WIDTH(SW), .SAMPLES(NS)) dut (
        .CLK(CLK), .resetn(resetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .ch_en(ch_en),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .beat_cnt(beat_cnt), .err_tlast(err_tlast)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DOW-1:0] d;
        logic           l;
    } beat_t;

    beat_t       q[$];
    logic        err_m;
    logic [31:0] cnt_m;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: integer sum of enabled channels, clamped when saturation is built in
    function automatic logic [DOW-1:0] model_sum(input logic [DW-1:0] d, input logic [NC-1:0] e);
        logic [DOW-1:0]       r;
        logic signed [SW-1:0] v;
        logic [31:0]          su;
        int                   s;
        r = '0;
        for (int i = 0; i < NS; i++) begin
            s = 0;
            for (int c = 0; c < NC; c++) begin
                if (e[c]) begin
                    v = d[(c*NS+i)*SW +: SW];
                    s = s + int'(v);
                end
            end
`ifdef AXIS_ADDER_SAT_EN
            if (s > (1 << (SW-1)) - 1) s = (1 << (SW-1)) - 1;
            if (s < -(1 << (SW-1)))    s = -(1 << (SW-1));
`endif
            su = s;
            r[i*MW +: MW] = su[MW-1:0];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] all_samples(input logic [SW-1:0] val);
        logic [DW-1:0] d;
        for (int k = 0; k < NC*NS; k++) d[k*SW +: SW] = val;
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        logic [31:0]   r;
        for (int k = 0; k < NC*NS; k++) begin
            r = $urandom;
            case (r[1:0])
                2'd0:    d[k*SW +: SW] = 16'h7FFF;
                2'd1:    d[k*SW +: SW] = 16'h8000;
                default: d[k*SW +: SW] = r[31:16];
            endcase
        end
        return d;
    endfunction

    // One clock: drive at negedge, check against model, then advance the model
    task automatic cycle(input logic [DW-1:0] d, input logic [NC-1:0] v,
                         input logic [NC-1:0] l, input logic [NC-1:0] e, input logic mr);
        logic  acc;
        beat_t b;
        @(negedge CLK);
        s_axis_tdata  = d;
        s_axis_tvalid = v;
        s_axis_tlast  = l;
        ch_en         = e;
        m_axis_tready = mr;
        #1;
        acc = (|e) && ((v | ~e) == 4'hF) && (q.size() < 2);
        check("s_tready", s_axis_tready, acc ? e : 4'h0);
        check("m_tvalid", m_axis_tvalid, q.size() != 0);
        check("beat_cnt", beat_cnt, cnt_m);
        check("err_tlast", err_tlast, err_m);
        if (q.size() != 0 && mr) begin
            check("m_tdata", m_axis_tdata, q[0].d);
            check("m_tlast", m_axis_tlast, q[0].l);
            void'(q.pop_front());
            cnt_m++;
        end
        if (acc) begin
            b.d = model_sum(d, e);
            b.l = |(l & e);
            q.push_back(b);
            if ((l & e) != 4'h0 && (l & e) != e) err_m = 1'b1;
        end
    endtask

    // Just after the accept edge: head sample 0 must hold the known constant
    task automatic check_head(input string tag, input logic [MW-1:0] exp);
        @(posedge CLK);
        #1;
        check({tag, "_valid"}, m_axis_tvalid, 1'b1);
        check(tag, m_axis_tdata[MW-1:0], exp);
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge, released just after a posedge
    task automatic do_reset();
        #2;
        resetn = 1'b0;
        #1;
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tready", s_axis_tready, 4'h0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_tdata", m_axis_tdata, '0);
        check("rst_beat_cnt", beat_cnt, 32'd0);
        check("rst_err", err_tlast, 1'b0);
        q.delete();
        err_m = 1'b0;
        cnt_m = '0;
        s_axis_tvalid = '0;
        ch_en         = '0;
        m_axis_tready = 1'b0;
        @(posedge CLK);
        #2;
        resetn = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [31:0]   r;
        logic [4:0]    pat;
        logic [NC-1:0] l;
        resetn        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        ch_en         = '0;
        m_axis_tready = 1'b0;
        err_m         = 1'b0;
        cnt_m         = '0;
        do_reset();

        // Largest positive inputs
        cycle(all_samples(16'h7FFF), 4'hF, 4'h0, 4'hF, 1'b1);
`ifdef AXIS_ADDER_SAT_EN
        check_head("max_sum", 16'h7FFF);
`else
        check_head("max_sum", 18'h1FFFC);
`endif
        cycle('0, 4'h0, 4'h0, 4'hF, 1'b1);

        // Most negative inputs
        cycle(all_samples(16'h8000), 4'hF, 4'h0, 4'hF, 1'b1);
`ifdef AXIS_ADDER_SAT_EN
        check_head("min_sum", 16'h8000);
`else
        check_head("min_sum", 18'h20000);
`endif
        cycle('0, 4'h0, 4'h0, 4'hF, 1'b1);

        // 1 + 2 - 3 + 0 cancels to zero
        d = '0;
        for (int i = 0; i < NS; i++) begin
            d[(0*NS+i)*SW +: SW] = 16'h0001;
            d[(1*NS+i)*SW +: SW] = 16'h0002;
            d[(2*NS+i)*SW +: SW] = 16'hFFFD;
        end
        cycle(d, 4'hF, 4'h0, 4'hF, 1'b1);
        check_head("zero_sum", '0);
        cycle('0, 4'h0, 4'h0, 4'hF, 1'b1);

        // Partial mask with disabled channels idle, then empty mask
        cycle(rand_data(), 4'b0101, 4'h0, 4'b0101, 1'b1);
        cycle(rand_data(), 4'hF, 4'h0, 4'h0, 1'b1);
        cycle(rand_data(), 4'hF, 4'h0, 4'h0, 1'b1);

        // Continuous input against a stalling sink
        pat = 5'b11001;
        for (int k = 0; k < 25; k++) cycle(rand_data(), 4'hF, 4'h0, 4'hF, pat[4 - (k % 5)]);
        for (int k = 0; k < 3; k++) cycle('0, 4'h0, 4'h0, 4'hF, 1'b1);

        // Random traffic with consistent tlast
        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            l = r[8] ? 4'hF : 4'h0;
            cycle(rand_data(), r[3:0] | {4{r[9]}}, l, r[7:4], r[10] | r[11]);
        end

        // Disagreeing tlast sets the sticky error
        cycle(rand_data(), 4'hF, 4'b0011, 4'hF, 1'b1);
        for (int k = 0; k < 4; k++) cycle(rand_data(), 4'hF, 4'hF, 4'hF, 1'b1);
        check("err_sticky", err_tlast, 1'b1);

        // Reset while the FIFO is full
        for (int k = 0; k < 3; k++) cycle(rand_data(), 4'hF, 4'h0, 4'hF, 1'b0);
        check("full_before_rst", q.size(), 2);
        do_reset();
        cycle(all_samples(16'h0005), 4'hF, 4'h0, 4'hF, 1'b1);
        check_head("post_rst_sum", MW'(20));
        cycle(rand_data(), 4'hF, 4'h0, 4'hF, 1'b1);

        // Random traffic including tlast disagreement
        for (int k = 0; k < 150; k++) begin
            r = $urandom;
            cycle(rand_data(), r[3:0] | {4{r[9]}}, r[15:12], r[7:4], r[10] | r[11]);
        end
        for (int k = 0; k < 3; k++) cycle('0, 4'h0, 4'h0, 4'hF, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
